// File: rtl/serial_load_pkg.sv
// Shared types and defaults for the serial load-value receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_load_pkg;

   localparam int DATA_W_DEF      = 8;
   localparam int SYNC_STAGES_DEF = 2;

   // Frame receiver states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      OVER   = 2'd2,
      COMMIT = 2'd3
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer for one async pin plus a delay flop for edge detection.
// Latency: level/rise/fall valid STAGES clk after the pin changes.
// Backpressure: none; every sampled edge is reported for exactly one clk.
module sync_edge
   import serial_load_pkg::*;
#(
   parameter int   STAGES  = SYNC_STAGES_DEF,   // must be >= 2
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_dly;

   // Shift the pin through the synchronizer chain and keep one older copy for edges
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= {STAGES{RST_VAL}};
         r_dly  <= RST_VAL;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_dly  <= r_sync[STAGES-1];
      end
   end

   assign o_level = r_sync[STAGES-1];
   assign o_rise  =  r_sync[STAGES-1] & ~r_dly;
   assign o_fall  = ~r_sync[STAGES-1] &  r_dly;

endmodule

// File: rtl/serial_load_ctrl.sv
// Receives an MSB-first load value over sclk/sdi/cs_n and commits it to the counter.
// Latency: load_strobe one clk after the synchronized cs_n rise (SYNC_STAGES+1..+3 clk from pin).
// Backpressure: none; bad-length frames are dropped and flagged in sticky frame_err.
module serial_load_ctrl
   import serial_load_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              sdi,
   input  logic              cs_n,
   input  logic              err_clr,
   output logic [DATA_W-1:0] load_data,
   output logic              load_strobe,
   output logic              busy,
   output logic              frame_err
);

   localparam int             CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

   logic w_sclk_rise, w_sclk_level_unused, w_sclk_fall_unused;
   logic w_sdi_s,     w_sdi_rise_unused,   w_sdi_fall_unused;
   logic w_cs_rise,   w_cs_fall,           w_cs_level_unused;

   state_t            r_state;
   logic [DATA_W-1:0] r_shreg;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [DATA_W-1:0] r_load_data;
   logic              r_load_strobe;
   logic              r_busy;
   logic              r_frame_err;

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .i_clk(clk), .i_rst(rst), .i_d(sclk),
      .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall_unused)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
      .i_clk(clk), .i_rst(rst), .i_d(sdi),
      .o_level(w_sdi_s), .o_rise(w_sdi_rise_unused), .o_fall(w_sdi_fall_unused)
   );

   // cs_n resets low so a select held low across reset never looks like a frame start
   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
      .i_clk(clk), .i_rst(rst), .i_d(cs_n),
      .o_level(w_cs_level_unused), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
   );

   // Frame FSM; load_data is captured on the COMMIT entry edge so it is valid with the strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_shreg       <= '0;
         r_bit_cnt     <= '0;
         r_load_data   <= '0;
         r_load_strobe <= 1'b0;
         r_busy        <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_load_strobe <= 1'b0;
         // clear first so a same-cycle error set below wins
         if (err_clr) r_frame_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_cs_fall) begin
                  r_bit_cnt <= '0;
                  r_state   <= SHIFT;
                  r_busy    <= 1'b1;
               end
            end
            SHIFT: begin
               // cs_rise outranks a coincident sclk_rise, which is dropped
               if (w_cs_rise) begin
                  if (r_bit_cnt == CNT_FULL) begin
                     r_state       <= COMMIT;
                     r_load_data   <= r_shreg;
                     r_load_strobe <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= IDLE;
                     r_busy      <= 1'b0;
                  end
               end else if (w_sclk_rise) begin
                  if (r_bit_cnt == CNT_FULL) begin
                     r_state <= OVER;
                  end else begin
                     r_shreg   <= {r_shreg[DATA_W-2:0], w_sdi_s};
                     r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  end
               end
            end
            OVER: begin
               if (w_cs_rise) begin
                  r_frame_err <= 1'b1;
                  r_state     <= IDLE;
                  r_busy      <= 1'b0;
               end
            end
            COMMIT: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign load_data   = r_load_data;
   assign load_strobe = r_load_strobe;
   assign busy        = r_busy;
   assign frame_err   = r_frame_err;

endmodule
